rv32i_fetch: RTL and testbench

//  Instruction-fetch stage of the rv32i pipeline; feeds the decode stage. Holds the PC, issues

---
 rtl/rv32i_fetch.sv | 195 +++++++++++++++++++
 tb/tb_rv32i_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch.sv
// -----------------------------------------------------------------------------
// rv32i_fetch
//   Instruction-fetch stage of the rv32i pipeline. It holds the PC, keeps at
//   most one request outstanding to instruction memory, and hands each fetched
//   instruction and its PC to decode together with a clock enable (o_ce).
//   Back-pressure from decode is absorbed by a one-entry skid buffer. Redirects
//   flush the stage. A redirect that arrives while a request is still in flight
//   marks the late response to be thrown away.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   o_iaddr      word-aligned instruction memory address
//   o_stb_inst   request strobe (single outstanding request)
//   i_ack_inst   memory response valid, i_inst valid this cycle
//   i_inst       memory read data
//   i_stall      decode cannot accept, outputs hold
//   i_change_pc  redirect request (branch/jump/trap/mret), implies flush
//   i_new_pc     redirect target, bits [1:0] ignored
//   o_inst       instruction presented to decode
//   o_pc         PC of o_inst
//   o_ce         o_inst/o_pc valid, decode clock enable
// -----------------------------------------------------------------------------
module rv32i_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    input  logic        i_stall,
    input  logic        i_change_pc,
    input  logic [31:0] i_new_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_ce
);

    localparam logic [31:0] PC_START = {PC_RESET[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_SKID = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        drop_r, drop_s;
    logic [31:0] skid_inst_r, skid_inst_s;
    logic [31:0] skid_pc_r, skid_pc_s;
    logic [31:0] iaddr_r, iaddr_s;
    logic        stb_r, stb_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] opc_r, opc_s;
    logic        ce_r, ce_s;

    logic [31:0] pc_plus4_s;
    logic [31:0] new_pc_s;

    // PC increment wraps naturally from 32'hFFFF_FFFC to 0.
    assign pc_plus4_s = pc_r + 32'd4;
    assign new_pc_s   = {i_new_pc[31:2], 2'b00};

    assign o_iaddr    = iaddr_r;
    assign o_stb_inst = stb_r;
    assign o_inst     = inst_r;
    assign o_pc       = opc_r;
    assign o_ce       = ce_r;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= PC_START;
            drop_r      <= 1'b0;
            skid_inst_r <= 32'h0000_0000;
            skid_pc_r   <= 32'h0000_0000;
            iaddr_r     <= PC_START;
            stb_r       <= 1'b0;
            inst_r      <= 32'h0000_0000;
            opc_r       <= 32'h0000_0000;
            ce_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            drop_r      <= drop_s;
            skid_inst_r <= skid_inst_s;
            skid_pc_r   <= skid_pc_s;
            iaddr_r     <= iaddr_s;
            stb_r       <= stb_s;
            inst_r      <= inst_s;
            opc_r       <= opc_s;
            ce_r        <= ce_s;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        drop_s      = drop_r;
        skid_inst_s = skid_inst_r;
        skid_pc_s   = skid_pc_r;
        iaddr_s     = iaddr_r;
        stb_s       = stb_r;
        inst_s      = inst_r;
        opc_s       = opc_r;
        ce_s        = ce_r;

        case (state_r)
            ST_IDLE: begin
                // Acks seen here belong to nothing we issued and are ignored.
                if (i_change_pc) begin
                    pc_s    = new_pc_s;
                    iaddr_s = new_pc_s;
                    ce_s    = 1'b0;
                end else begin
                    iaddr_s = pc_r;
                end
                state_s = ST_REQ;
                stb_s   = 1'b1;
            end

            ST_REQ: begin
                if (i_change_pc) begin
                    pc_s = new_pc_s;
                    ce_s = 1'b0;
                    if (i_ack_inst) begin
                        // Response is for the old path; discard and fetch the target.
                        drop_s  = 1'b0;
                        iaddr_s = new_pc_s;
                    end else begin
                        // Request still in flight: keep the address stable and
                        // swallow its response when it finally comes back.
                        drop_s = 1'b1;
                    end
                end else if (i_ack_inst && drop_r) begin
                    // Stale response: no output update, pc already holds the target.
                    drop_s  = 1'b0;
                    iaddr_s = pc_r;
                end else if (i_ack_inst && !i_stall) begin
                    inst_s  = i_inst;
                    opc_s   = pc_r;
                    ce_s    = 1'b1;
                    pc_s    = pc_plus4_s;
                    iaddr_s = pc_plus4_s;
                end else if (i_ack_inst) begin
                    // Decode is stalled: park the instruction and stop requesting,
                    // so no further ack can arrive while the skid is full.
                    skid_inst_s = i_inst;
                    skid_pc_s   = pc_r;
                    pc_s        = pc_plus4_s;
                    iaddr_s     = pc_plus4_s;
                    stb_s       = 1'b0;
                    state_s     = ST_SKID;
                end else if (!i_stall) begin
                    ce_s = 1'b0;
                end else begin
                    ce_s = ce_r;
                end
            end

            ST_SKID: begin
                if (i_change_pc) begin
                    pc_s    = new_pc_s;
                    iaddr_s = new_pc_s;
                    ce_s    = 1'b0;
                    stb_s   = 1'b1;
                    state_s = ST_REQ;
                end else if (!i_stall) begin
                    inst_s  = skid_inst_r;
                    opc_s   = skid_pc_r;
                    ce_s    = 1'b1;
                    iaddr_s = pc_r;
                    stb_s   = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_SKID;
                end
            end

            default: begin
                state_s = ST_IDLE;
                stb_s   = 1'b0;
                drop_s  = 1'b0;
                iaddr_s = pc_r;
                ce_s    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rv32i_fetch.sv
// -----------------------------------------------------------------------------
// tb_rv32i_fetch
//   Bench for rv32i_fetch. A small memory model answers requests with a
//   programmable latency and a granted number of acks. Each directed phase
//   pushes the PCs decode must receive into a queue. A monitor compares every
//   consumed output (o_ce && !i_stall) against the front of that queue.
// -----------------------------------------------------------------------------
module tb_rv32i_fetch;

    logic        clk;
    logic        rst_n;
    logic        ack;
    logic [31:0] mem_inst;
    logic        stall;
    logic        change;
    logic [31:0] new_pc;
    logic [31:0] iaddr;
    logic        stb;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        ce;

    int n_chk;
    int n_fail;

    logic [31:0] exp_q[$];

    int   mem_lat;
    int   mem_grant;
    int   mem_given;
    int   wait_cnt;
    logic prev_stb;

    rv32i_fetch #(.PC_RESET(32'hFFFF_FFFF)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_iaddr     (iaddr),
        .o_stb_inst  (stb),
        .i_ack_inst  (ack),
        .i_inst      (mem_inst),
        .i_stall     (stall),
        .i_change_pc (change),
        .i_new_pc    (new_pc),
        .o_inst      (inst_out),
        .o_pc        (pc_out),
        .o_ce        (ce)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_empty(input string name, input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            #3;
            k++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d deliveries still pending after %0d cycles, expected 0",
                     name, exp_q.size(), limit);
        end
    endtask

    // Memory model: acks on the falling edge once the request has waited
    // mem_lat cycles, never in the cycle the strobe rises, and only while
    // granted acks remain.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            ack      = 1'b0;
            mem_inst = 32'h0000_0000;
            wait_cnt = 0;
            prev_stb = 1'b0;
        end else begin
            if (stb && prev_stb && (mem_given < mem_grant) && (wait_cnt >= mem_lat)) begin
                ack      = 1'b1;
                mem_inst = mem_data(iaddr);
                wait_cnt = 0;
                mem_given++;
            end else begin
                ack      = 1'b0;
                mem_inst = 32'h0000_0000;
                if (stb) wait_cnt++;
                else     wait_cnt = 0;
            end
            prev_stb = stb;
        end
    end

    // Monitor: every instruction consumed by decode must match the queue front.
    always begin
        logic [31:0] e;
        @(negedge clk);
        #2;
        if (rst_n && ce && !stall) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_delivery: got pc %h inst %h, expected none", pc_out, inst_out);
            end else begin
                e = exp_q.pop_front();
                check("deliver_pc", pc_out, e);
                check("deliver_inst", inst_out, mem_data(e));
            end
        end
    end

    // Directed stimulus.
    initial begin
        int          c104;
        int          ce104;
        int          k;
        logic [31:0] held;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        change    = 1'b0;
        new_pc    = 32'h0000_0000;
        ack       = 1'b0;
        mem_inst  = 32'h0000_0000;
        mem_lat   = 0;
        mem_grant = 0;
        mem_given = 0;
        wait_cnt  = 0;
        prev_stb  = 1'b0;

        // Reset state; PC_RESET low bits are forced to zero.
        repeat (3) @(negedge clk);
        #3;
        check("rst_stb", {31'd0, stb}, 32'd0);
        check("rst_iaddr", iaddr, 32'hFFFF_FFFC);
        check("rst_ce", {31'd0, ce}, 32'd0);
        check("rst_pc", pc_out, 32'h0000_0000);
        check("rst_inst", inst_out, 32'h0000_0000);

        // Back-to-back stream starting at the reset PC, wrapping to 0.
        exp_q.push_back(32'hFFFF_FFFC);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        mem_lat   = 0;
        mem_grant = mem_grant + 9;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_empty("stream", 60);

        // Redirect while the request to 0x20 is in flight (target low bits ignored).
        @(negedge clk);
        #1;
        change = 1'b1;
        new_pc = 32'h0000_0103;
        @(negedge clk);
        #1;
        change = 1'b0;
        #2;
        check("drop_iaddr_held", iaddr, 32'h0000_0020);
        check("drop_stb", {31'd0, stb}, 32'd1);
        check("drop_ce", {31'd0, ce}, 32'd0);

        // Latency 3: stale 0x20 ack discarded, then one inst every 4 cycles.
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        exp_q.push_back(32'h0000_0108);
        mem_lat   = 3;
        mem_grant = mem_grant + 4;
        c104  = 0;
        ce104 = 0;
        k     = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            #3;
            if (stb && iaddr == 32'h0000_0104) begin
                c104++;
                if (ce) ce104++;
            end
            k++;
        end
        check("lat_empty", 32'(exp_q.size()), 32'd0);
        check("lat_iaddr_hold_cycles", 32'(c104), 32'd4);
        check("lat_ce_in_window", 32'(ce104), 32'd1);

        // Stall for 5 cycles in the middle of a back-to-back stream at 0x200.
        @(negedge clk);
        #1;
        change = 1'b1;
        new_pc = 32'h0000_0200;
        @(negedge clk);
        #1;
        change = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h0000_0200 + 32'(i * 4));
        mem_lat   = 0;
        mem_grant = mem_grant + 9;
        k = 0;
        while (exp_q.size() > 5 && k < 40) begin
            @(negedge clk);
            #3;
            k++;
        end
        check("stall_prefix_consumed", 32'(exp_q.size()), 32'd5);
        held = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        stall = 1'b1;
        #2;
        check("stall_ce_held", {31'd0, ce}, 32'd1);
        check("stall_pc_held", pc_out, held);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            check("stall_stb_low", {31'd0, stb}, 32'd0);
            check("stall_pc_frozen", pc_out, held);
            check("stall_inst_frozen", inst_out, mem_data(held));
        end
        @(negedge clk);
        #1;
        stall = 1'b0;
        wait_empty("stall_release", 60);

        // Redirect in the same cycle as an ack while stalled: data dropped.
        mem_grant = mem_grant + 1;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            #1;
            if (ack) break;
            k++;
        end
        check("same_cycle_ack_seen", {31'd0, ack}, 32'd1);
        change = 1'b1;
        stall  = 1'b1;
        new_pc = 32'h0000_0100;
        @(negedge clk);
        #1;
        change = 1'b0;
        stall  = 1'b0;
        #2;
        check("same_cycle_iaddr", iaddr, 32'h0000_0100);
        check("same_cycle_stb", {31'd0, stb}, 32'd1);
        check("same_cycle_ce", {31'd0, ce}, 32'd0);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        mem_grant = mem_grant + 2;
        wait_empty("same_cycle_refetch", 40);

        // Asynchronous reset while the request to 0x108 is outstanding.
        repeat (2) @(negedge clk);
        #3;
        check("pre_reset_stb", {31'd0, stb}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_stb", {31'd0, stb}, 32'd0);
        check("async_rst_iaddr", iaddr, 32'hFFFF_FFFC);
        check("async_rst_ce", {31'd0, ce}, 32'd0);
        check("async_rst_pc", pc_out, 32'h0000_0000);
        check("async_rst_inst", inst_out, 32'h0000_0000);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        mem_grant = mem_grant + 3;
        @(negedge clk);
        #3;
        check("post_rst_stb", {31'd0, stb}, 32'd1);
        check("post_rst_iaddr", iaddr, 32'hFFFF_FFFC);
        wait_empty("post_rst_stream", 40);

        repeat (3) @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time bound in case any wait above misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
